// File: rtl/crypto_wb_serializer.sv
// crypto_wb_serializer: captures SM4 results and SM3 hashes from the crypto
// accelerator and writes them back to the register file one 32-bit word per
// accepted handshake, most-significant word first, on consecutive registers.
// Writes addressed to x0 are consumed silently. One pending slot queues a hash
// that arrives while a transfer is in flight.
// Optional build macro: CRYPTO_WB_BSWAP_EN (byte-reverse every output word).
module crypto_wb_serializer #(
    parameter int unsigned SM4_WORDS = 4,
    parameter int unsigned SM3_WORDS = 8,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic                      gated_clk,
    input  logic                      RST,
    input  logic                      sm4_done_i,
    input  logic [SM4_WORDS*32-1:0]   sm4_result_i,
    input  logic                      sm3_done_i,
    input  logic [SM3_WORDS*32-1:0]   sm3_hash_i,
    input  logic [ADDR_W-1:0]         rd_base_i,
    input  logic                      wb_ready_i,
    output logic                      wb_en_o,
    output logic [ADDR_W-1:0]         wb_addr_o,
    output logic [31:0]               wb_data_o,
    output logic                      hold_pipeline_o,
    output logic                      busy_o,
    output logic                      overflow_err_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SM4_W  = SM4_WORDS * WORD_W;
    localparam int unsigned SM3_W  = SM3_WORDS * WORD_W;
    localparam int unsigned CNT_W  = $clog2(SM3_WORDS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_SM4 = 2'd1,
        SEND_SM3 = 2'd2
    } state_t;

    state_t             state, n_state;
    logic [CNT_W-1:0]   cnt, n_cnt, last_idx;
    logic [SM3_W-1:0]   cur_data, n_data;
    logic [ADDR_W-1:0]  cur_base, n_base;
    logic               pend_valid, n_pend_valid;
    logic [SM3_W-1:0]   pend_data, n_pend_data;
    logic [ADDR_W-1:0]  pend_base, n_pend_base;
    logic               n_ovf;
    logic               adv;
    logic               can_start;
    logic [ADDR_W-1:0]  n_addr;
    logic [WORD_W-1:0]  n_word;
    logic [WORD_W-1:0]  n_word_out;

    // Next-state, slot bookkeeping and next output word selection
    always_comb begin
        n_state      = state;
        n_cnt        = cnt;
        n_data       = cur_data;
        n_base       = cur_base;
        n_pend_valid = pend_valid;
        n_pend_data  = pend_data;
        n_pend_base  = pend_base;
        n_ovf        = overflow_err_o;
        n_word       = '0;

        last_idx = (state == SEND_SM4) ? CNT_W'(SM4_WORDS - 1) : CNT_W'(SM3_WORDS - 1);
        // An x0 slot has wb_en_o low and simply advances after one cycle
        adv = (state != IDLE) && (wb_ready_i || !wb_en_o);

        if (adv) begin
            if (cnt == last_idx) begin
                n_cnt = '0;
                if (pend_valid) begin
                    n_state      = SEND_SM3;
                    n_data       = pend_data;
                    n_base       = pend_base;
                    n_pend_valid = 1'b0;
                end else begin
                    n_state = IDLE;
                end
            end else begin
                n_cnt = cnt + CNT_W'(1);
            end
        end

        // A done pulse on the final-accept edge sees the engine as free
        can_start = (n_state == IDLE);

        if (sm4_done_i) begin
            if (can_start) begin
                n_state = SEND_SM4;
                n_data  = {sm4_result_i, {(SM3_W - SM4_W){1'b0}}};
                n_base  = rd_base_i;
                n_cnt   = '0;
            end else begin
                n_ovf = 1'b1;
            end
        end

        if (sm3_done_i) begin
            if (can_start && !sm4_done_i) begin
                n_state = SEND_SM3;
                n_data  = sm3_hash_i;
                n_base  = rd_base_i;
                n_cnt   = '0;
            end else if (!n_pend_valid) begin
                n_pend_valid = 1'b1;
                n_pend_data  = sm3_hash_i;
                n_pend_base  = rd_base_i;
            end else begin
                n_ovf = 1'b1;
            end
        end

        n_addr = n_base + ADDR_W'(n_cnt);
        for (int unsigned i = 0; i < SM3_WORDS; i++) begin
            if (n_cnt == CNT_W'(i)) begin
                n_word = n_data[SM3_W - 1 - i * WORD_W -: WORD_W];
            end
        end

`ifdef CRYPTO_WB_BSWAP_EN
        n_word_out = {n_word[7:0], n_word[15:8], n_word[23:16], n_word[31:24]};
`else
        n_word_out = n_word;
`endif
    end

    // State, slot and registered output update
    always_ff @(posedge gated_clk) begin
        if (!RST) begin
            state           <= IDLE;
            cnt             <= '0;
            cur_data        <= '0;
            cur_base        <= '0;
            pend_valid      <= 1'b0;
            pend_data       <= '0;
            pend_base       <= '0;
            wb_en_o         <= 1'b0;
            wb_addr_o       <= '0;
            wb_data_o       <= '0;
            hold_pipeline_o <= 1'b0;
            busy_o          <= 1'b0;
            overflow_err_o  <= 1'b0;
        end else begin
            state           <= n_state;
            cnt             <= n_cnt;
            cur_data        <= n_data;
            cur_base        <= n_base;
            pend_valid      <= n_pend_valid;
            pend_data       <= n_pend_data;
            pend_base       <= n_pend_base;
            wb_en_o         <= (n_state != IDLE) && (n_addr != '0);
            wb_addr_o       <= (n_state != IDLE) ? n_addr : '0;
            wb_data_o       <= (n_state != IDLE) ? n_word_out : '0;
            hold_pipeline_o <= (n_state != IDLE) || n_pend_valid;
            busy_o          <= (n_state != IDLE) || n_pend_valid;
            overflow_err_o  <= n_ovf;
        end
    end

endmodule
